// File: rtl/murax_led_ctrl.sv
// LED arbiter for the iCE40 Murax board: boot sweep, breathing heartbeat, or CPU-driven
// GPIO A pattern, with a software watchdog that returns the LEDs to the heartbeat.
module murax_led_ctrl #(
    parameter int LED_WIDTH   = 8,
    parameter int STEP_DIV    = 22,
    parameter int BOOT_SWEEPS = 2,
    parameter int PWM_BITS    = 8,
    parameter int HB_DIV      = 4,
    parameter int WDT_CYCLES  = 12000000,
    parameter int KICK_BIT    = 31
) (
    input  logic                 io_mainClk,
    input  logic                 io_resetn,
    input  logic [31:0]          io_gpioA_write,
    input  logic [31:0]          io_gpioA_writeEnable,
    output logic [LED_WIDTH-1:0] io_led,
    output logic                 io_owner,
    output logic                 io_wdt_expired
);

    localparam int BOOT_STEPS = LED_WIDTH * BOOT_SWEEPS;
    localparam int STEP_W     = $clog2(BOOT_STEPS + 1);
    localparam int POS_W      = (LED_WIDTH > 1) ? $clog2(LED_WIDTH) : 1;
    localparam int WDT_W      = $clog2(WDT_CYCLES);

    localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(BOOT_STEPS);
    localparam logic [POS_W-1:0]     POS_LAST  = POS_W'(LED_WIDTH - 1);
    localparam logic [WDT_W-1:0]     WDT_LAST  = WDT_W'(WDT_CYCLES - 1);
    localparam logic [PWM_BITS-1:0]  DUTY_MAX  = '1;
    localparam logic [PWM_BITS-1:0]  DUTY_TOP  = DUTY_MAX - 1'b1;
    localparam logic [PWM_BITS-1:0]  DUTY_ONE  = PWM_BITS'(1);
    localparam logic [LED_WIDTH-1:0] LED_ONE   = LED_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_HEARTBEAT,
        ST_CPU
    } state_e;

    state_e                state_q, state_d;
    logic [STEP_DIV-1:0]   div_q, div_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic [PWM_BITS-1:0]   pwm_q, pwm_d;
    logic [HB_DIV-1:0]     pre_q, pre_d;
    logic [PWM_BITS-1:0]   duty_q, duty_d;
    logic                  dir_q, dir_d;      // 1 = duty falling
    logic [WDT_W-1:0]      wdt_q, wdt_d;
    logic                  kick_q;
    logic                  armed_q, armed_d;
    logic [LED_WIDTH-1:0]  led_q, led_d;
    logic                  owner_q, owner_d;
    logic                  expired_q, expired_d;

    logic [LED_WIDTH-1:0]  led_en;
    logic                  take;
    logic                  kick;
    logic                  expire;
    logic                  boot_done;
    logic                  unused_gpio;

    assign led_en    = io_gpioA_writeEnable[LED_WIDTH-1:0];
    assign take      = armed_q && (led_en != '0);
    assign kick      = io_gpioA_write[KICK_BIT] != kick_q;
    assign expire    = (state_q == ST_CPU) && !kick && (wdt_q == WDT_LAST);
    assign boot_done = (step_q == STEP_LAST);

    // Only the LED lanes and the kick bit matter; fold the rest away.
    assign unused_gpio = ^{io_gpioA_write, io_gpioA_writeEnable};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // NOTE: reset is sampled on the clock edge (synchronous), and every register
    // here uses non-blocking assignment so all of them update from the same snapshot.
    always_ff @(posedge io_mainClk) begin
        if (!io_resetn) begin
            state_q   <= ST_BOOT;
            div_q     <= '0;
            step_q    <= '0;
            pos_q     <= '0;
            pwm_q     <= '0;
            pre_q     <= '0;
            duty_q    <= '0;
            dir_q     <= 1'b0;
            wdt_q     <= '0;
            kick_q    <= 1'b0;
            armed_q   <= 1'b1;
            led_q     <= '0;
            owner_q   <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            step_q    <= step_d;
            pos_q     <= pos_d;
            pwm_q     <= pwm_d;
            pre_q     <= pre_d;
            duty_q    <= duty_d;
            dir_q     <= dir_d;
            wdt_q     <= wdt_d;
            kick_q    <= io_gpioA_write[KICK_BIT];
            armed_q   <= armed_d;
            led_q     <= led_d;
            owner_q   <= owner_d;
            expired_q <= expired_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state: takeover beats every other transition
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: begin
                if (take)           state_d = ST_CPU;
                else if (boot_done) state_d = ST_HEARTBEAT;
            end
            ST_HEARTBEAT: begin
                if (take) state_d = ST_CPU;
            end
            ST_CPU: begin
                if (expire) state_d = ST_HEARTBEAT;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters: boot sweep, free-running breathing generator, watchdog
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of a combinational block,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        div_d   = div_q;
        step_d  = step_q;
        pos_d   = pos_q;
        pwm_d   = pwm_q + 1'b1;
        pre_d   = pre_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        wdt_d   = '0;
        armed_d = armed_q;

        if (state_q == ST_BOOT && !boot_done) begin
            div_d = div_q + 1'b1;
            if (div_q == '1) begin
                step_d = step_q + 1'b1;
                pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
            end
        end

        // Breathing phase keeps running in every state so a revoke resumes mid-breath.
        if (pwm_q == '1) begin
            pre_d = pre_q + 1'b1;
            if (pre_q == '1) begin
                if (dir_q) begin
                    duty_d = duty_q - 1'b1;
                    if (duty_q == DUTY_ONE) dir_d = 1'b0;
                end else begin
                    duty_d = duty_q + 1'b1;
                    if (duty_q == DUTY_TOP) dir_d = 1'b1;
                end
            end
        end

        // Held at zero outside CPU mode, which also clears it on entry.
        if (state_q == ST_CPU && !kick && !expire) wdt_d = wdt_q + 1'b1;

        if (expire)              armed_d = 1'b0;
        else if (led_en == '0)   armed_d = 1'b1;
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from the next state so changes land on the same edge
    // ------------------------------------------------------------------
    always_comb begin
        led_d     = '0;
        owner_d   = 1'b0;
        expired_d = 1'b0;
        unique case (state_d)
            ST_BOOT: begin
                led_d = LED_ONE << pos_q;
            end
            ST_HEARTBEAT: begin
                led_d[0]  = (state_q != ST_BOOT) && (pwm_q < duty_q);
                expired_d = (state_q == ST_CPU);
            end
            ST_CPU: begin
                led_d   = led_en & io_gpioA_write[LED_WIDTH-1:0];
                owner_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign io_led         = led_q;
    assign io_owner       = owner_q;
    assign io_wdt_expired = expired_q;

endmodule

// File: tb/tb_murax_led_ctrl.sv
// Directed bench for murax_led_ctrl with shortened timing; the driver queues the expected
// LED/owner/expiry triple for each edge and a monitor compares after that edge.
module tb_murax_led_ctrl;

    logic        io_mainClk = 1'b0;
    logic        io_resetn;
    logic [31:0] io_gpioA_write;
    logic [31:0] io_gpioA_writeEnable;
    logic [7:0]  io_led;
    logic        io_owner;
    logic        io_wdt_expired;

    typedef struct {
        logic [7:0] led;
        logic       owner;
        logic       expd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   k        = 0;   // edges since reset release

    murax_led_ctrl #(
        .LED_WIDTH  (8),
        .STEP_DIV   (2),
        .BOOT_SWEEPS(1),
        .PWM_BITS   (4),
        .HB_DIV     (1),
        .WDT_CYCLES (100),
        .KICK_BIT   (31)
    ) dut (
        .io_mainClk          (io_mainClk),
        .io_resetn           (io_resetn),
        .io_gpioA_write      (io_gpioA_write),
        .io_gpioA_writeEnable(io_gpioA_writeEnable),
        .io_led              (io_led),
        .io_owner            (io_owner),
        .io_wdt_expired      (io_wdt_expired)
    );

    always #5 io_mainClk = ~io_mainClk;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at output %0d: got %0h, expected %0h", name, idx, act, req);
        end
    endtask

    // Boot sweep: each one-hot value held for 4 edges, edge i counted from 1.
    function automatic logic [7:0] boot_led(input int i);
        return 8'(1 << ((i - 1) / 4));
    endfunction

    // Heartbeat LED0 on edge i: PWM period 16, duty steps every 32 edges as a
    // 0..15..0 triangle with a 30-step period.
    function automatic logic [7:0] hb_led(input int i);
        int j, pwm, s, m, duty;
        j    = i - 1;
        pwm  = j % 16;
        s    = j / 32;
        m    = s % 30;
        duty = (m <= 15) ? m : 30 - m;
        return (pwm < duty) ? 8'h01 : 8'h00;
    endfunction

    task automatic drive(input logic rn, input logic [31:0] we, input logic [31:0] wr,
                         input logic [7:0] el, input logic eo, input logic ee);
        exp_t e;
        @(negedge io_mainClk);
        io_resetn            = rn;
        io_gpioA_writeEnable = we;
        io_gpioA_write       = wr;
        e.led   = el;
        e.owner = eo;
        e.expd  = ee;
        sb_q.push_back(e);
        k = rn ? k + 1 : 0;
    endtask

    // Monitor: one output triple per edge, compared after it settles.
    initial begin
        exp_t e;
        int   idx = 0;
        forever begin
            @(posedge io_mainClk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                idx++;
                check("io_led",         idx, {24'd0, io_led},         {24'd0, e.led});
                check("io_owner",       idx, {31'd0, io_owner},       {31'd0, e.owner});
                check("io_wdt_expired", idx, {31'd0, io_wdt_expired}, {31'd0, e.expd});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got %0d checks, expected completion", n_checks);
        $fatal(1, "time limit");
    end

    initial begin
        logic        t;
        logic [31:0] wrv;
        io_resetn            = 1'b0;
        io_gpioA_write       = '0;
        io_gpioA_writeEnable = '0;
        t                    = 1'b0;

        // Reset, full boot sweep, then a complete breathing cycle.
        repeat (2) drive(1'b0, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 32; i++) drive(1'b1, 32'h0, 32'h0, boot_led(i), 1'b0, 1'b0);
        drive(1'b1, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0);
        while (k < 1000) drive(1'b1, 32'h0, 32'h0, hb_led(k + 1), 1'b0, 1'b0);

        // Restart and take over on the 10th boot edge.
        drive(1'b0, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) drive(1'b1, 32'h0, 32'h0, boot_led(i), 1'b0, 1'b0);
        drive(1'b1, 32'hFF, 32'hA5, 8'hA5, 1'b1, 1'b0);
        repeat (3) drive(1'b1, 32'h0F, 32'hA5, 8'h05, 1'b1, 1'b0);

        // Kick every 50 edges: never expires; last kick on the final edge.
        wrv = '0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 50 == 49) t = ~t;
            wrv = {t, 23'd0, 8'(i * 7)};
            drive(1'b1, 32'hFF, wrv, wrv[7:0], 1'b1, 1'b0);
        end

        // Kick landing exactly when the counter sits at 99 wins over expiry.
        repeat (99) drive(1'b1, 32'hFF, wrv, wrv[7:0], 1'b1, 1'b0);
        t       = ~t;
        wrv[31] = t;
        drive(1'b1, 32'hFF, wrv, wrv[7:0], 1'b1, 1'b0);

        // Silence: expiry on the 100th edge, then heartbeat continues its phase.
        repeat (99) drive(1'b1, 32'hFF, wrv, wrv[7:0], 1'b1, 1'b0);
        drive(1'b1, 32'hFF, wrv, hb_led(k + 1), 1'b0, 1'b1);
        repeat (40) drive(1'b1, 32'hFF, wrv, hb_led(k + 1), 1'b0, 1'b0);

        // Re-arm with one zero-enable edge, then retake.
        drive(1'b1, 32'h0, wrv, hb_led(k + 1), 1'b0, 1'b0);
        repeat (4) drive(1'b1, 32'hFF, 32'h3C, 8'h3C, 1'b1, 1'b0);

        // One-edge reset in CPU mode with enables held: cleared, then immediate takeover.
        drive(1'b0, 32'hFF, 32'h5A, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 32'hFF, 32'h5A, 8'h5A, 1'b1, 1'b0);

        // Reset with enables released: sweep starts again from bit 0.
        drive(1'b0, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) drive(1'b1, 32'h0, 32'h0, boot_led(i), 1'b0, 1'b0);

        repeat (3) @(negedge io_mainClk);
        check("scoreboard_drained", 0, 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
